// File: rtl/video_timing_pkg.sv
// Shared timing presets and helpers for the raster timing generator.
// Each preset gives active/front/sync/back for one axis.
package video_timing_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned front;
        int unsigned sync;
        int unsigned back;
    } axis_timing_t;

    localparam axis_timing_t VGA_640X480_60_H = '{active: 640, front: 16, sync: 96, back: 48};
    localparam axis_timing_t VGA_640X480_60_V = '{active: 480, front: 10, sync: 2,  back: 33};

    localparam axis_timing_t S86_NATIVE_H = '{active: 512, front: 16, sync: 48, back: 64};
    localparam axis_timing_t S86_NATIVE_V = '{active: 240, front: 4,  sync: 3,  back: 15};

    function automatic int unsigned axis_total(input axis_timing_t t);
        return t.active + t.front + t.sync + t.back;
    endfunction

endpackage

// File: rtl/video_axis_counter.sv
// One raster axis: wrapping position counter with resync load and
// registered blank/sync decode of the position being loaded.
module video_axis_counter
    import video_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = 640,
    parameter int unsigned FRONT  = 16,
    parameter int unsigned SYNC   = 96,
    parameter int unsigned BACK   = 48,
    parameter int unsigned RESYNC = 0,
    parameter int unsigned WIDTH  = 12
) (
    input  logic             i_Clk,
    input  logic             i_nRst,
    input  logic             i_Step,
    input  logic             i_Load,
    output logic             o_Wrap,
    output logic [WIDTH-1:0] o_Count,
    output logic             o_Blank,
    output logic             o_nSync
);

    localparam int unsigned TOTAL      = ACTIVE + FRONT + SYNC + BACK;
    localparam int unsigned SYNC_START = ACTIVE + FRONT;
    localparam int unsigned SYNC_END   = SYNC_START + SYNC;

    if (64'(TOTAL) > (64'd1 << WIDTH)) begin : g_bad_total
        $error("video_axis_counter: TOTAL does not fit in WIDTH");
    end
    if (ACTIVE == 0 || SYNC == 0) begin : g_bad_zero
        $error("video_axis_counter: ACTIVE and SYNC must be non-zero");
    end
    if (RESYNC >= TOTAL) begin : g_bad_resync
        $error("video_axis_counter: RESYNC must be below TOTAL");
    end

    logic [WIDTH-1:0] r_Count;
    logic             r_Blank;
    logic             r_nSync;
    logic [WIDTH-1:0] w_Next;
    logic [31:0]      w_CountExt;
    logic [31:0]      w_NextExt;

    assign w_CountExt = 32'(r_Count);
    assign o_Wrap     = i_Step & (w_CountExt == TOTAL - 1);

    always_comb begin
        w_Next = r_Count;
        if (i_Load)
            w_Next = WIDTH'(RESYNC);
        else if (o_Wrap)
            w_Next = '0;
        else if (i_Step)
            w_Next = r_Count + 1'b1;
    end

    assign w_NextExt = 32'(w_Next);

    // Decode the incoming position so flags line up with the count register.
    always_ff @(posedge i_Clk or negedge i_nRst) begin
        if (!i_nRst) begin
            r_Count <= '0;
            r_Blank <= 1'b0;
            r_nSync <= 1'b1;
        end else begin
            r_Count <= w_Next;
            r_Blank <= (w_NextExt >= ACTIVE);
            r_nSync <= !((w_NextExt >= SYNC_START) && (w_NextExt < SYNC_END));
        end
    end

    assign o_Count = r_Count;
    assign o_Blank = r_Blank;
    assign o_nSync = r_nSync;

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with pixel clock-enable and genlock
// resync; all outputs describe the position currently held in o_X/o_Y.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_WIDTH           = 12,
    parameter int unsigned V_WIDTH           = 12,
    parameter int unsigned H_ACTIVE          = VGA_640X480_60_H.active,
    parameter int unsigned H_FRONT           = VGA_640X480_60_H.front,
    parameter int unsigned H_SYNC            = VGA_640X480_60_H.sync,
    parameter int unsigned H_BACK            = VGA_640X480_60_H.back,
    parameter int unsigned V_ACTIVE          = VGA_640X480_60_V.active,
    parameter int unsigned V_FRONT           = VGA_640X480_60_V.front,
    parameter int unsigned V_SYNC            = VGA_640X480_60_V.sync,
    parameter int unsigned V_BACK            = VGA_640X480_60_V.back,
    parameter int unsigned H_RESYNC          = 0,
    parameter int unsigned V_RESYNC          = 0,
    parameter int unsigned FRAME_COUNT_WIDTH = 8
) (
    input  logic                         i_Clk,
    input  logic                         i_nRst,
    input  logic                         i_CE,
    input  logic                         i_Resync,
    output logic [H_WIDTH-1:0]           o_X,
    output logic [V_WIDTH-1:0]           o_Y,
    output logic                         o_nHSync,
    output logic                         o_nVSync,
    output logic                         o_HBlank,
    output logic                         o_VBlank,
    output logic                         o_Active,
    output logic                         o_LineStart,
    output logic                         o_FrameStart,
    output logic [FRAME_COUNT_WIDTH-1:0] o_FrameCount
);

    localparam logic RESYNC_LINE  = (H_RESYNC == 0);
    localparam logic RESYNC_FRAME = (H_RESYNC == 0) && (V_RESYNC == 0);

    logic                         r_Pending;
    logic                         r_LineStart;
    logic                         r_FrameStart;
    logic [FRAME_COUNT_WIDTH-1:0] r_FrameCount;
    logic                         w_ResyncReq;
    logic                         w_Apply;
    logic                         w_HStep;
    logic                         w_HWrap;
    logic                         w_VWrap;
    logic                         w_LineStart;
    logic                         w_FrameStart;

    // A request waits until the next enabled cycle; that cycle loads instead of advancing.
    assign w_ResyncReq  = i_Resync | r_Pending;
    assign w_Apply      = i_CE & w_ResyncReq;
    assign w_HStep      = i_CE & ~w_Apply;
    assign w_LineStart  = w_Apply ? RESYNC_LINE  : w_HWrap;
    assign w_FrameStart = w_Apply ? RESYNC_FRAME : (w_HWrap & w_VWrap);

    video_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK),
        .RESYNC (H_RESYNC),
        .WIDTH  (H_WIDTH)
    ) u_h_axis (
        .i_Clk   (i_Clk),
        .i_nRst  (i_nRst),
        .i_Step  (w_HStep),
        .i_Load  (w_Apply),
        .o_Wrap  (w_HWrap),
        .o_Count (o_X),
        .o_Blank (o_HBlank),
        .o_nSync (o_nHSync)
    );

    video_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK),
        .RESYNC (V_RESYNC),
        .WIDTH  (V_WIDTH)
    ) u_v_axis (
        .i_Clk   (i_Clk),
        .i_nRst  (i_nRst),
        .i_Step  (w_HWrap),
        .i_Load  (w_Apply),
        .o_Wrap  (w_VWrap),
        .o_Count (o_Y),
        .o_Blank (o_VBlank),
        .o_nSync (o_nVSync)
    );

    always_ff @(posedge i_Clk or negedge i_nRst) begin
        if (!i_nRst) begin
            r_Pending    <= 1'b0;
            r_LineStart  <= 1'b0;
            r_FrameStart <= 1'b0;
            r_FrameCount <= '0;
        end else begin
            r_Pending    <= w_ResyncReq & ~i_CE;
            r_LineStart  <= w_LineStart;
            r_FrameStart <= w_FrameStart;
            if (w_FrameStart)
                r_FrameCount <= r_FrameCount + 1'b1;
        end
    end

    assign o_Active     = ~o_HBlank & ~o_VBlank;
    assign o_LineStart  = r_LineStart;
    assign o_FrameStart = r_FrameStart;
    assign o_FrameCount = r_FrameCount;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a small raster, with two
// instances differing only in their resync target.
module tb_video_timing_gen;

    localparam int HA = 4, HF = 1, HS = 1, HB = 2;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic       nhs;
        logic       nvs;
        logic       hb;
        logic       vb;
        logic       act;
        logic       ls;
        logic       fs;
        logic [1:0] fc;
    } exp_t;

    typedef struct packed {
        exp_t       a;
        exp_t       b;
        logic [2:0] phase;
    } sb_t;

    logic       i_Clk = 1'b0;
    logic       i_nRst = 1'b0;
    logic       i_CE = 1'b0;
    logic       i_Resync = 1'b0;

    logic [3:0] a_X, b_X;
    logic [3:0] a_Y, b_Y;
    logic       a_nHSync, a_nVSync, a_HBlank, a_VBlank, a_Active, a_LineStart, a_FrameStart;
    logic       b_nHSync, b_nVSync, b_HBlank, b_VBlank, b_Active, b_LineStart, b_FrameStart;
    logic [1:0] a_FrameCount, b_FrameCount;

    video_timing_gen #(
        .H_WIDTH(4), .V_WIDTH(4),
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_RESYNC(0), .V_RESYNC(0), .FRAME_COUNT_WIDTH(2)
    ) dut_a (
        .i_Clk(i_Clk), .i_nRst(i_nRst), .i_CE(i_CE), .i_Resync(i_Resync),
        .o_X(a_X), .o_Y(a_Y), .o_nHSync(a_nHSync), .o_nVSync(a_nVSync),
        .o_HBlank(a_HBlank), .o_VBlank(a_VBlank), .o_Active(a_Active),
        .o_LineStart(a_LineStart), .o_FrameStart(a_FrameStart), .o_FrameCount(a_FrameCount)
    );

    video_timing_gen #(
        .H_WIDTH(4), .V_WIDTH(4),
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_RESYNC(5), .V_RESYNC(2), .FRAME_COUNT_WIDTH(2)
    ) dut_b (
        .i_Clk(i_Clk), .i_nRst(i_nRst), .i_CE(i_CE), .i_Resync(i_Resync),
        .o_X(b_X), .o_Y(b_Y), .o_nHSync(b_nHSync), .o_nVSync(b_nVSync),
        .o_HBlank(b_HBlank), .o_VBlank(b_VBlank), .o_Active(b_Active),
        .o_LineStart(b_LineStart), .o_FrameStart(b_FrameStart), .o_FrameCount(b_FrameCount)
    );

    always #5 i_Clk = ~i_Clk;

    int   total = 0;
    int   bad = 0;
    sb_t  sb_q[$];
    logic [2:0] phase = 3'd0;

    // Reference model: raster position, pending request, strobes, frame count.
    int mx[2], my[2], mfc[2];
    bit mpend[2], mls[2], mfs[2];

    function automatic int h_resync(input int k);
        return (k == 0) ? 0 : 5;
    endfunction

    function automatic int v_resync(input int k);
        return (k == 0) ? 0 : 2;
    endfunction

    function automatic exp_t expect_of(input int k);
        exp_t e;
        e.x   = 4'(mx[k]);
        e.y   = 4'(my[k]);
        e.hb  = (mx[k] >= HA);
        e.vb  = (my[k] >= VA);
        e.nhs = !((mx[k] >= HA + HF) && (mx[k] < HA + HF + HS));
        e.nvs = !((my[k] >= VA + VF) && (my[k] < VA + VF + VS));
        e.act = !e.hb && !e.vb;
        e.ls  = mls[k];
        e.fs  = mfs[k];
        e.fc  = 2'(mfc[k]);
        return e;
    endfunction

    function automatic exp_t got_a();
        exp_t g;
        g.x = a_X; g.y = a_Y; g.nhs = a_nHSync; g.nvs = a_nVSync; g.hb = a_HBlank;
        g.vb = a_VBlank; g.act = a_Active; g.ls = a_LineStart; g.fs = a_FrameStart; g.fc = a_FrameCount;
        return g;
    endfunction

    function automatic exp_t got_b();
        exp_t g;
        g.x = b_X; g.y = b_Y; g.nhs = b_nHSync; g.nvs = b_nVSync; g.hb = b_HBlank;
        g.vb = b_VBlank; g.act = b_Active; g.ls = b_LineStart; g.fs = b_FrameStart; g.fc = b_FrameCount;
        return g;
    endfunction

    task automatic model_step(input bit nrst, input bit ce, input bit rs);
        for (int k = 0; k < 2; k++) begin
            bit req;
            if (!nrst) begin
                mx[k] = 0; my[k] = 0; mpend[k] = 0; mls[k] = 0; mfs[k] = 0; mfc[k] = 0;
            end else begin
                req = rs || mpend[k];
                mls[k] = 0;
                mfs[k] = 0;
                if (ce && req) begin
                    mx[k] = h_resync(k);
                    my[k] = v_resync(k);
                    mpend[k] = 0;
                    mls[k] = (mx[k] == 0);
                    mfs[k] = (mx[k] == 0) && (my[k] == 0);
                end else begin
                    mpend[k] = req;
                    if (ce) begin
                        if (mx[k] == HT - 1) begin
                            mx[k] = 0;
                            my[k] = (my[k] + 1) % VT;
                            mls[k] = 1;
                            mfs[k] = (my[k] == 0);
                        end else begin
                            mx[k] = mx[k] + 1;
                        end
                    end
                end
                if (mfs[k])
                    mfc[k] = (mfc[k] + 1) % 4;
            end
        end
    endtask

    task automatic compare(input string name, input exp_t got, input exp_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got x=%0d y=%0d nhs=%b nvs=%b hb=%b vb=%b act=%b ls=%b fs=%b fc=%0d required x=%0d y=%0d nhs=%b nvs=%b hb=%b vb=%b act=%b ls=%b fs=%b fc=%0d",
                     name, $time, got.x, got.y, got.nhs, got.nvs, got.hb, got.vb, got.act, got.ls, got.fs, got.fc,
                     exp.x, exp.y, exp.nhs, exp.nvs, exp.hb, exp.vb, exp.act, exp.ls, exp.fs, exp.fc);
        end
    endtask

    task automatic step(input bit nrst, input bit ce, input bit rs);
        sb_t s;
        @(posedge i_Clk);
        #2;
        i_nRst = nrst;
        i_CE = ce;
        i_Resync = rs;
        model_step(nrst, ce, rs);
        s.a = expect_of(0);
        s.b = expect_of(1);
        s.phase = phase;
        sb_q.push_back(s);
    endtask

    task automatic async_reset();
        sb_t s;
        @(posedge i_Clk);
        #2;
        i_nRst = 1'b0;
        i_CE = 1'b0;
        i_Resync = 1'b0;
        model_step(1'b0, 1'b0, 1'b0);
        #1;
        compare("async_reset_a", got_a(), expect_of(0));
        compare("async_reset_b", got_b(), expect_of(1));
        s.a = expect_of(0);
        s.b = expect_of(1);
        s.phase = phase;
        sb_q.push_back(s);
    endtask

    // Monitor: compares each post-edge state and the FrameStart period in steady phases.
    initial begin
        sb_t e;
        int  cyc = 0;
        int  last_fs = -1;
        logic [2:0] last_phase = 3'd0;
        forever begin
            @(posedge i_Clk);
            #1;
            cyc++;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                compare("dut_a", got_a(), e.a);
                compare("dut_b", got_b(), e.b);
                if (e.phase != last_phase) begin
                    last_fs = -1;
                    last_phase = e.phase;
                end
                if (a_FrameStart && (e.phase == 3'd1 || e.phase == 3'd2)) begin
                    if (last_fs >= 0) begin
                        total++;
                        if (cyc - last_fs != ((e.phase == 3'd1) ? HT * VT : 2 * HT * VT)) begin
                            bad++;
                            $display("FAIL fs_period phase=%0d got %0d required %0d", e.phase,
                                     cyc - last_fs, (e.phase == 3'd1) ? HT * VT : 2 * HT * VT);
                        end
                    end
                    last_fs = cyc;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int budget;
        model_step(1'b0, 1'b0, 1'b0);

        phase = 3'd0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        phase = 3'd1;
        repeat (4 * HT * VT) step(1'b1, 1'b1, 1'b0);

        phase = 3'd2;
        repeat (3 * HT * VT) begin
            step(1'b1, 1'b1, 1'b0);
            step(1'b1, 1'b0, 1'b0);
        end

        phase = 3'd3;
        repeat (1500) step(1'b1, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);

        phase = 3'd4;
        budget = 0;
        while (!(mx[0] == 2 && my[0] == 1) && budget < 200) begin
            step(1'b1, 1'b1, 1'b0);
            budget++;
        end
        total++;
        if (budget >= 200) begin
            bad++;
            $display("FAIL reach_resync_point got timeout required (2,1)");
        end
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        repeat (3) step(1'b1, 1'b1, 1'b0);

        phase = 3'd5;
        budget = 0;
        while (!(mx[0] == HA + HF && my[0] == VA + VF) && budget < 200) begin
            step(1'b1, 1'b1, 1'b0);
            budget++;
        end
        total++;
        if (budget >= 200) begin
            bad++;
            $display("FAIL reach_sync_point got timeout required (%0d,%0d)", HA + HF, VA + VF);
        end
        async_reset();
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        repeat (10) step(1'b1, 1'b1, 1'b0);

        repeat (3) @(posedge i_Clk);
        #3;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got %0d entries required 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
